// File: rtl/arm_mem_pkg.sv
// Shared definitions for the instruction/data RAM arbiter.
//   owner_e  : which processor port owns the access in flight
//   state_e  : arbiter sequencing states
//   WORD_W   : RAM / bus word width
//   addr_err : byte-address range and alignment check
package arm_mem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    // Error when the byte address is not word aligned or lies beyond the
    // RAM (any bit above the word-index field is set).
    function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                      input int unsigned       addr_w);
        logic [WORD_W-1:0] hi;
        hi = addr >> (addr_w + 2);
        return (addr[1:0] != 2'b00) || (hi != '0);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority pick between the fetch (I) and data (D) ports with a
// starvation guard for I.
//   clk, rst          : clock, asynchronous active-high reset
//   allow_i           : arbiter can accept a request this cycle
//   i_req_i, d_req_i  : port requests
//   grant_i_o         : I request accepted this cycle
//   grant_d_o         : D request accepted this cycle
module mem_arb_pick
    import arm_mem_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic allow_i,
    input  logic i_req_i,
    input  logic d_req_i,
    output logic grant_i_o,
    output logic grant_d_o
);

    localparam int unsigned CNT_W = $clog2(MAX_STREAK + 1);

    logic [CNT_W-1:0] streak_q;
    logic [CNT_W-1:0] streak_d;
    logic             starve;

    always_comb begin
        starve    = (streak_q == CNT_W'(MAX_STREAK));
        // D wins a tie unless I has already waited out MAX_STREAK D grants.
        grant_d_o = allow_i & d_req_i & ~(i_req_i & starve);
        grant_i_o = allow_i & i_req_i & ~grant_d_o;

        streak_d = streak_q;
        if (!i_req_i || grant_i_o) begin
            streak_d = '0;
        end else if (grant_d_o && !starve) begin
            streak_d = streak_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous word RAM between the instruction-fetch
// port (I) and the load/store port (D). Each accepted request spends one
// cycle in ISSUE (RAM access) and one in RESP (response pulse); a new
// request may be accepted in RESP, giving one access per two cycles.
//   clk, reset                      : clock, asynchronous active-high reset
//   i_req/i_addr -> i_gnt           : fetch request handshake
//   i_rvalid/i_rdata/i_err          : fetch response
//   d_req/d_we/d_be/d_addr/d_wdata  : data request, d_gnt accepts it
//   d_rvalid/d_rdata/d_err          : data response (loads and stores)
//   ram_en/we/be/addr/wdata         : RAM command, driven only in ISSUE
//   ram_rdata                       : RAM read data, cycle after ram_en
module mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [WORD_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [WORD_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata
);

    if (ADDR_W != $clog2(DEPTH)) begin : g_bad_cfg
        $error("mem_arbiter: ADDR_W must equal clog2(DEPTH)");
    end

    state_e            state_q;
    owner_e            owner_q;
    logic              err_q;
    logic              we_q;
    logic              ram_en_q;
    logic              ram_we_q;
    logic [3:0]        ram_be_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [WORD_W-1:0] ram_wdata_q;
    logic              i_rvalid_q;
    logic              i_err_q;
    logic              i_pass_q;
    logic              d_rvalid_q;
    logic              d_err_q;
    logic              d_pass_q;

    logic              allow;
    logic              grant_i;
    logic              grant_d;
    logic [WORD_W-1:0] req_addr;
    logic              req_err;
    logic              req_we;
    logic [3:0]        req_be;
    logic [WORD_W-1:0] req_wdata;

    // Grants are held off during reset so every output reads 0.
    assign allow = ~reset & ((state_q == IDLE) | (state_q == RESP));

    mem_arb_pick #(
        .MAX_STREAK(MAX_STREAK)
    ) u_pick (
        .clk      (clk),
        .rst      (reset),
        .allow_i  (allow),
        .i_req_i  (i_req),
        .d_req_i  (d_req),
        .grant_i_o(grant_i),
        .grant_d_o(grant_d)
    );

    // Payload of whichever request is being accepted; I never writes.
    always_comb begin
        req_addr  = grant_d ? d_addr : i_addr;
        req_err   = addr_err(req_addr, ADDR_W);
        req_we    = grant_d & d_we;
        req_be    = grant_d ? d_be : 4'b1111;
        req_wdata = grant_d ? d_wdata : '0;
    end

    // RAM command and response strobes are registered on the transition
    // into ISSUE / RESP respectively and default back to 0 the cycle after.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            i_rvalid_q  <= 1'b0;
            i_err_q     <= 1'b0;
            i_pass_q    <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_pass_q    <= 1'b0;
        end else begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            i_rvalid_q  <= 1'b0;
            i_err_q     <= 1'b0;
            i_pass_q    <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_pass_q    <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (grant_i || grant_d) begin
                        state_q     <= ISSUE;
                        owner_q     <= grant_d ? OWN_D : OWN_I;
                        err_q       <= req_err;
                        we_q        <= req_we;
                        ram_en_q    <= ~req_err;
                        ram_we_q    <= req_we & ~req_err;
                        ram_be_q    <= req_be;
                        ram_addr_q  <= req_addr[ADDR_W+1:2];
                        ram_wdata_q <= req_wdata;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    state_q <= RESP;
                    if (owner_q == OWN_D) begin
                        d_rvalid_q <= 1'b1;
                        d_err_q    <= err_q;
                        d_pass_q   <= ~err_q & ~we_q;
                    end else begin
                        i_rvalid_q <= 1'b1;
                        i_err_q    <= err_q;
                        i_pass_q   <= ~err_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_gnt     = grant_i;
    assign d_gnt     = grant_d;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_be    = ram_be_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign i_rvalid  = i_rvalid_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_pass_q ? ram_rdata : '0;
    assign d_rvalid  = d_rvalid_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_pass_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned MAXS   = 4;

    logic              clk;
    logic              reset;
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    mem_arbiter #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .MAX_STREAK(MAXS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_be   (ram_be),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM plus a preload port owned by the bench.
    logic [31:0]       mem [DEPTH];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0]       pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we && ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int unsigned w, input logic [31:0] v);
        pl_en   = 1'b1;
        pl_addr = ADDR_W'(w);
        pl_data = v;
        tick();
        pl_en   = 1'b0;
    endtask

    function automatic logic outs_zero();
        return ~|{i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
                  ram_en, ram_we, ram_be, ram_addr, ram_wdata};
    endfunction

    // One isolated access on either port; called at posedge+1, returns at
    // posedge+2 of the response cycle (or after the wait bound expires).
    task automatic do_acc(input logic use_d, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic got, output logic [31:0] rd,
                          output logic er, output logic en_seen);
        int n;
        got = 1'b0; rd = '0; er = 1'b0; en_seen = 1'b0;
        if (use_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        #1;
        n = 0;
        while (!(use_d ? d_gnt : i_gnt) && n < 20) begin
            tick(); #1; n++;
        end
        if (!(use_d ? d_gnt : i_gnt)) begin
            d_req = 1'b0; i_req = 1'b0;
            return;
        end
        tick();
        d_req = 1'b0; i_req = 1'b0; d_we = 1'b0;
        #1;
        n = 0;
        while (!(use_d ? d_rvalid : i_rvalid) && n < 10) begin
            if (ram_en) en_seen = 1'b1;
            tick(); #1; n++;
        end
        if (use_d ? d_rvalid : i_rvalid) begin
            got = 1'b1;
            rd  = use_d ? d_rdata : i_rdata;
            er  = use_d ? d_err : i_err;
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_en;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } rsp_t;

    function automatic logic [31:0] rnd_addr();
        int unsigned k = $urandom_range(0, 9);
        logic [31:0] w = 32'($urandom_range(0, 15)) << 2;
        if (k == 0) return w | 32'($urandom_range(1, 3));
        if (k == 1) return w | (32'h4000 << $urandom_range(0, 17));
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [11];
        logic        got, er, en;
        logic [31:0] rd;
        int          ng, nv, last, t0;
        logic        g;
        logic [31:0] shadow [16];
        rsp_t        q [$];
        logic        eg_i, eg_d, i_took, d_took, busy;
        int          streak;

        n_checks = 0; n_fail = 0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        reset = 1'b1;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h20; d_wdata = 32'h1;

        // ---------------- reset state ----------------
        tick(); #1;
        check("rst_outs_during", 64'(outs_zero()), 64'd1);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("rst_outs_release", 64'(outs_zero()), 64'd1);
        tick(); #1;
        check("rst_outs_after", 64'(outs_zero()), 64'd1);
        tick();

        // ---------------- I-only load ----------------
        preload(5, 32'hDEADBEEF);
        i_req = 1'b1; i_addr = 32'h14;
        #1;
        check("ild_gnt", 64'({i_gnt, d_gnt}), 64'b10);
        tick();
        i_req = 1'b0;
        #1;
        check("ild_issue", 64'({ram_en, ram_we, ram_addr, i_rvalid}), 64'({1'b1, 1'b0, 12'd5, 1'b0}));
        tick(); #1;
        check("ild_resp", 64'({i_rvalid, i_err, i_rdata}), 64'({1'b1, 1'b0, 32'hDEADBEEF}));
        tick();

        // ---------------- table-driven D accesses ----------------
        preload(8, 32'hFFFFFFFF);
        preload(9, 32'h11111111);
        preload(4095, 32'hA5A50F0F);
        vt[0]  = '{1'b1, 4'b0011, 32'h20,       32'h12345678, 32'h0,        1'b0, 1'b1};
        vt[1]  = '{1'b0, 4'b1111, 32'h20,       32'h0,        32'hFFFF5678, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 4'b1111, 32'h22,       32'h0,        32'h0,        1'b1, 1'b0};
        vt[3]  = '{1'b1, 4'b1111, 32'h21,       32'h0,        32'h0,        1'b1, 1'b0};
        vt[4]  = '{1'b0, 4'b1111, 32'h20,       32'h0,        32'hFFFF5678, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 4'b1111, 32'h3FFC,     32'h0,        32'hA5A50F0F, 1'b0, 1'b1};
        vt[6]  = '{1'b0, 4'b1111, 32'h4000,     32'h0,        32'h0,        1'b1, 1'b0};
        vt[7]  = '{1'b1, 4'b1111, 32'h80000024, 32'h0,        32'h0,        1'b1, 1'b0};
        vt[8]  = '{1'b0, 4'b1111, 32'h24,       32'h0,        32'h11111111, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 4'b1100, 32'h24,       32'hCAFEBABE, 32'h0,        1'b0, 1'b1};
        vt[10] = '{1'b0, 4'b1111, 32'h24,       32'h0,        32'hCAFE1111, 1'b0, 1'b1};
        for (int k = 0; k < 11; k++) begin
            do_acc(1'b1, vt[k].we, vt[k].be, vt[k].addr, vt[k].wdata, got, rd, er, en);
            check($sformatf("vec%0d_done", k), 64'(got), 64'd1);
            check($sformatf("vec%0d_rdata", k), 64'(rd), 64'(vt[k].exp_rdata));
            check($sformatf("vec%0d_err", k), 64'(er), 64'(vt[k].exp_err));
            check($sformatf("vec%0d_ram_en", k), 64'(en), 64'(vt[k].exp_en));
            tick();
        end

        // ---------------- I out-of-range ----------------
        do_acc(1'b0, 1'b0, 4'hF, 32'h0000_4000, 32'h0, got, rd, er, en);
        check("ierr_done", 64'(got), 64'd1);
        check("ierr_resp", 64'({er, rd, en}), 64'({1'b1, 32'h0, 1'b0}));
        tick();

        // ---------------- contention ----------------
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h4;
        #1;
        ng = 0; last = 0;
        for (int c = 0; c < 60 && ng < 12; c++) begin
            if (i_gnt && d_gnt) check("cont_both", 64'd1, 64'd0);
            if (i_gnt || d_gnt) begin
                check($sformatf("cont_owner%0d", ng), 64'(d_gnt), 64'((ng % (MAXS + 1)) != MAXS));
                if (ng > 0) check($sformatf("cont_gap%0d", ng), 64'(c - last), 64'd2);
                last = c;
                ng++;
            end
            tick(); #1;
        end
        check("cont_count", 64'(ng), 64'd12);
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick(); tick();

        // ---------------- back-to-back D loads ----------------
        for (int k = 0; k < 8; k++) preload(32 + k, 32'hB0000000 + 32'(k));
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80;
        #1;
        ng = 0; nv = 0; t0 = 0; last = 0;
        for (int c = 0; c < 40 && nv < 8; c++) begin
            if (d_rvalid) begin
                check($sformatf("b2b_data%0d", nv), 64'(d_rdata), 64'(32'hB0000000 + 32'(nv)));
                check($sformatf("b2b_when%0d", nv), 64'(c - t0), 64'(2 + 2 * nv));
                last = c;
                nv++;
            end
            g = d_gnt && (ng < 8);
            if (g) begin
                if (ng == 0) t0 = c;
                ng++;
            end
            tick();
            if (ng == 8) d_req = 1'b0;
            else if (g) d_addr = 32'h80 + 32'(4 * ng);
            #1;
        end
        check("b2b_count", 64'(nv), 64'd8);
        check("b2b_span", 64'(last - t0), 64'd16);
        tick();

        // ---------------- reset mid-RESP ----------------
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        #1;
        check("rmid_gnt", 64'(d_gnt), 64'd1);
        tick();
        d_req = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("rmid_outs", 64'(outs_zero()), 64'd1);
        tick(); #1;
        check("rmid_outs_hold", 64'(outs_zero()), 64'd1);
        tick();
        reset = 1'b0;
        #1;
        check("rmid_release", 64'(outs_zero()), 64'd1);
        tick(); #1;
        check("rmid_after", 64'(outs_zero()), 64'd1);
        tick();

        // ---------------- randomized traffic vs. transaction model ----------------
        for (int k = 0; k < 16; k++) begin
            shadow[k] = $urandom;
            preload(k, shadow[k]);
        end
        busy = 1'b0; streak = 0; i_took = 1'b0; d_took = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (c >= 294) begin
                i_req = 1'b0; d_req = 1'b0;
            end else begin
                if (!i_req || i_took) begin
                    i_req  = 1'($urandom_range(0, 1));
                    i_addr = rnd_addr();
                end
                if (!d_req || d_took) begin
                    d_req   = 1'($urandom_range(0, 1));
                    d_addr  = rnd_addr();
                    d_we    = 1'($urandom_range(0, 1));
                    d_be    = 4'($urandom_range(0, 15));
                    d_wdata = $urandom;
                end
            end
            #1;
            // a grant is possible unless one was given at the previous edge
            eg_d = !busy && d_req && !(i_req && streak == MAXS);
            eg_i = !busy && i_req && !eg_d;
            check("rnd_gnt", 64'({i_gnt, d_gnt}), 64'({eg_i, eg_d}));
            if (q.size() > 0 && q[0].due == c) begin
                check("rnd_irsp", 64'({i_rvalid, i_err, i_rdata}),
                      q[0].is_d ? 64'd0 : 64'({1'b1, q[0].err, q[0].rdata}));
                check("rnd_drsp", 64'({d_rvalid, d_err, d_rdata}),
                      q[0].is_d ? 64'({1'b1, q[0].err, q[0].rdata}) : 64'd0);
                void'(q.pop_front());
            end else begin
                check("rnd_idle_rsp", 64'({i_rvalid, d_rvalid}), 64'd0);
            end
            if (eg_i || eg_d) begin
                rsp_t        r;
                logic [31:0] a;
                a       = eg_d ? d_addr : i_addr;
                r.is_d  = eg_d;
                r.err   = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
                r.rdata = '0;
                r.due   = c + 2;
                if (!r.err) begin
                    if (eg_d && d_we) begin
                        for (int b = 0; b < 4; b++)
                            if (d_be[b]) shadow[a[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
                    end else begin
                        r.rdata = shadow[a[5:2]];
                    end
                end
                q.push_back(r);
            end
            if (!i_req || eg_i) streak = 0;
            else if (eg_d && streak < MAXS) streak++;
            busy   = eg_i || eg_d;
            i_took = i_gnt;
            d_took = d_gnt;
            tick();
        end
        check("rnd_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
